// File: rtl/iq_capture_pkg.sv
// Shared types and helpers for the I/Q snapshot capture buffer.
package iq_capture_pkg;

  // Capture controller states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } cap_state_t;

  // Native sample width of the rate changer output.
  localparam int unsigned IQ_WIDTH = 14;

  // One stored sample; I occupies the MSBs of the RAM word.
  typedef struct packed {
    logic signed [IQ_WIDTH-1:0] i;
    logic signed [IQ_WIDTH-1:0] q;
  } iq_sample_t;

  // Window length in samples for a given address width.
  function automatic int unsigned depth_of(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/iq_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module iq_capture_ram
  import iq_capture_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 28
) (
  input  logic          clkin320,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = depth_of(AW);

  logic [DW-1:0] mem [0:WORDS-1];

  // Write port.
  always_ff @(posedge clkin320) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clkin320) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iq_capture_buffer.sv
// Triggered snapshot capture of the 320 MHz I/Q stream with valid/ready readout.
module iq_capture_buffer
  import iq_capture_pkg::*;
#(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned PRETRIG    = 64
) (
  input  logic               clkin320,
  input  logic               reset,
  input  logic               dcm_locked,
  input  logic [WIDTH-1:0]   i_in,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [WIDTH-1:0]   trig_level,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_last,
  output logic               busy,
  output logic               aborted
);

  localparam int unsigned DEPTH = depth_of(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] PRE_CNT  = DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] POST_CNT = DEPTH_LOG2'(DEPTH - PRETRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);

  if (PRETRIG < 1 || PRETRIG > DEPTH - 1) begin : g_bad_pretrig
    $error("iq_capture_buffer: PRETRIG must lie in 1 .. 2**DEPTH_LOG2-1");
  end

  typedef struct packed {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] q;
  } sample_t;

  cap_state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] sa;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [WIDTH-1:0]      prev_i;

  logic                  capturing;
  logic                  wr_en;
  logic                  lock_lost;
  logic                  level_cross;
  logic                  trig_hit;
  sample_t               wr_sample;

  // Read pipeline: RAM output stage, output register and skid register.
  logic [DEPTH_LOG2:0]   issue_cnt;
  logic [DEPTH_LOG2-1:0] out_cnt;
  logic [DEPTH_LOG2-1:0] raddr;
  logic                  rd_issue;
  logic                  p1_valid;
  logic [2*WIDTH-1:0]    ram_rdata;
  logic                  out_valid;
  logic [2*WIDTH-1:0]    out_data;
  logic                  skid_valid;
  logic [2*WIDTH-1:0]    skid_data;
  logic                  xfer;
  logic                  rd_done;
  logic [1:0]            held;

  // Write-side decode: what happens to the incoming sample this cycle.
  always_comb begin
    capturing   = (state == PRE) || (state == WAIT) || (state == POST);
    wr_en       = capturing && dcm_locked;
    lock_lost   = capturing && !dcm_locked;
    level_cross = ($signed(prev_i) < $signed(trig_level)) &&
                  ($signed(i_in) >= $signed(trig_level));
    trig_hit    = (state == WAIT) && wr_en && (level_cross || force_trig);
    wr_sample.i = i_in;
    wr_sample.q = q_in;
  end

  // Read-side decode. A new RAM read is issued only if the output and skid
  // registers can absorb every word already in flight plus this one.
  always_comb begin
    xfer     = out_valid && rd_ready;
    rd_done  = xfer && (out_cnt == '1);
    held     = 2'(p1_valid) + 2'(out_valid) + 2'(skid_valid) - 2'(xfer);
    rd_issue = (state == READ) && !issue_cnt[DEPTH_LOG2] && (held <= 2'd1);
    raddr    = sa + issue_cnt[DEPTH_LOG2-1:0];
  end

  // State register.
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; lock loss anywhere in the capture phases aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = PRE;
        end
      end
      PRE: begin
        if (lock_lost) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_ONE) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lock_lost) begin
          state_nxt = IDLE;
        end else if (trig_hit) begin
          state_nxt = (POST_CNT == '0) ? READ : POST;
        end
      end
      POST: begin
        if (lock_lost) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_ONE) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (rd_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer, window counter, trigger history, start address and abort flag.
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      sa      <= '0;
      cnt     <= '0;
      prev_i  <= '0;
      aborted <= 1'b0;
    end else begin
      if (wr_en) begin
        wp     <= wp + 1'b1;
        prev_i <= i_in;
      end
      if ((state == IDLE) && arm) begin
        cnt     <= PRE_CNT;
        aborted <= 1'b0;
      end else if (trig_hit) begin
        cnt <= POST_CNT;
        sa  <= wp - PRE_CNT;
      end else if (wr_en && ((state == PRE) || (state == POST))) begin
        cnt <= cnt - 1'b1;
      end
      if (lock_lost) begin
        aborted <= 1'b1;
      end
    end
  end

  iq_capture_ram #(
    .AW (DEPTH_LOG2),
    .DW (2*WIDTH)
  ) u_ram (
    .clkin320 (clkin320),
    .we       (wr_en),
    .waddr    (wp),
    .wdata    (wr_sample),
    .re       (rd_issue),
    .raddr    (raddr),
    .rdata    (ram_rdata)
  );

  // Readout pipeline. A word leaving the RAM goes straight to the output
  // register when it is free, otherwise it parks in the skid register;
  // the skid word always drains first so ordering is preserved.
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      issue_cnt  <= '0;
      out_cnt    <= '0;
      p1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (state != READ) begin
      issue_cnt  <= '0;
      out_cnt    <= '0;
      p1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      p1_valid <= rd_issue;
      if (rd_issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (xfer) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (!out_valid || rd_ready) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= p1_valid;
          if (p1_valid) begin
            skid_data <= ram_rdata;
          end
        end else if (p1_valid) begin
          out_data  <= ram_rdata;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (p1_valid) begin
        skid_data  <= ram_rdata;
        skid_valid <= 1'b1;
      end
    end
  end

  // Output drive.
  always_comb begin
    rd_valid = out_valid;
    rd_data  = out_data;
    rd_last  = out_valid && (out_cnt == '1);
    busy     = (state != IDLE);
  end

endmodule
